// File: rtl/seq_calculator.sv
// Sequential calculator: latches operands on start, runs concat/add/sub in one
// cycle and shift-add multiply / restoring divide one bit per cycle.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | waiting for start_pi; result/ovflw hold the last completed op
//  EXEC  | op accepted, busy; iterative ops advance one bit per cycle
module seq_calculator #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk_pi,
    input  logic                 rst_n_pi,
    input  logic                 start_pi,
    input  logic [WIDTH-1:0]     data1_pi,
    input  logic [WIDTH-1:0]     data2_pi,
    input  logic [3:0]           op_pi,
    input  logic [CNT_W-1:0]     counter_pi,
    output logic                 busy_po,
    output logic                 done_po,
    output logic [2*WIDTH-1:0]   result_po,
    output logic                 ovflw_po
);

    localparam int RW = 2 * WIDTH;
    localparam int SW = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_CAT = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b1000;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t          state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [3:0]      op_q;
    logic [RW-1:0]   cnt_q;
    logic [RW-1:0]   acc_q;
    logic [SW-1:0]   step_q;
    logic [RW-1:0]   result_q;
    logic            ovflw_q;
    logic            busy_q;
    logic            done_q;

    logic [WIDTH:0]   mul_sum_d;
    logic [RW-1:0]    mul_d;
    logic [WIDTH:0]   div_sh_d;
    logic [WIDTH-1:0] div_sub_d;
    logic             div_ge_d;
    logic [RW-1:0]    div_d;
    logic [WIDTH:0]   add_d;
    logic             last_step_d;
    logic [RW-1:0]    res_d;
    logic             ovf_d;
    logic             fin_d;

    generate
        if (CNT_W > RW) begin : g_cnt_hi
            logic cnt_hi_unused;
            assign cnt_hi_unused = ^counter_pi[CNT_W-1:RW];
        end
    endgenerate

    // Iterative datapath. For mul acc_q = {partial sum, remaining multiplier bits};
    // for div acc_q = {partial remainder, dividend bits shifting into quotient}.
    always_comb begin
        mul_sum_d   = {1'b0, acc_q[RW-1:WIDTH]} +
                      (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        mul_d       = {mul_sum_d, acc_q[WIDTH-1:1]};
        div_sh_d    = {acc_q[RW-1:WIDTH], acc_q[WIDTH-1]};
        div_ge_d    = (div_sh_d >= {1'b0, b_q});
        div_sub_d   = div_sh_d[WIDTH-1:0] - b_q;
        div_d       = {(div_ge_d ? div_sub_d : div_sh_d[WIDTH-1:0]),
                       acc_q[WIDTH-2:0], div_ge_d};
        add_d       = {1'b0, a_q} + {1'b0, b_q};
        last_step_d = (step_q == SW'(WIDTH - 1));
    end

    always_comb begin
        res_d = cnt_q;
        ovf_d = 1'b0;
        fin_d = 1'b1;
        case (op_q)
            OP_CAT: res_d = {a_q, b_q};
            OP_ADD: begin
                res_d = {{WIDTH{1'b0}}, add_d[WIDTH-1:0]};
                ovf_d = add_d[WIDTH];
            end
            OP_SUB: begin
                res_d = {{WIDTH{1'b0}}, a_q - b_q};
                ovf_d = (a_q < b_q);
            end
            OP_MUL: begin
                res_d = mul_d;
                fin_d = last_step_d;
            end
            // Divide by zero naturally yields quotient all ones, remainder = dividend.
            OP_DIV: begin
                res_d = div_d;
                ovf_d = (b_q == '0);
                fin_d = last_step_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_pi) begin
        if (!rst_n_pi) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            step_q   <= '0;
            result_q <= '0;
            ovflw_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_pi) begin
                        a_q     <= data1_pi;
                        b_q     <= data2_pi;
                        op_q    <= op_pi;
                        cnt_q   <= counter_pi[RW-1:0];
                        acc_q   <= (op_pi == OP_DIV) ? {{WIDTH{1'b0}}, data1_pi}
                                                     : {{WIDTH{1'b0}}, data2_pi};
                        step_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    step_q <= step_q + SW'(1);
                    if (op_q == OP_MUL) begin
                        acc_q <= mul_d;
                    end else if (op_q == OP_DIV) begin
                        acc_q <= div_d;
                    end
                    if (fin_d) begin
                        result_q <= res_d;
                        ovflw_q  <= ovf_d;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_po   = busy_q;
    assign done_po   = done_q;
    assign result_po = result_q;
    assign ovflw_po  = ovflw_q;

endmodule
